// File: rtl/stream_demux.sv
// Registered 1-to-NUM_OUT stream demultiplexer with valid/ready flow control.
// Each channel owns a one-entry holding register; broadcast is all-or-nothing.
module stream_demux #(
  parameter int DATA_W  = 8,
  parameter int NUM_OUT = 8,
  parameter int SEL_W   = $clog2(NUM_OUT),
  parameter int CNT_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      in_bcast,
  output logic [NUM_OUT-1:0]        out_valid,
  input  logic [NUM_OUT-1:0]        out_ready,
  output logic [NUM_OUT*DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]          drop_cnt
);

  localparam int NUM_PAD = 1 << SEL_W;

  logic [NUM_OUT-1:0] free;
  // Select codes past NUM_OUT read as "free" so out-of-range beats are always taken.
  logic [NUM_PAD-1:0] free_pad;
  logic               sel_ok;
  logic               accept;
  logic               drop;
  logic [CNT_W-1:0]   drop_cnt_reg;

  assign sel_ok   = int'(in_sel) < NUM_OUT;
  assign in_ready = in_bcast ? (&free) : (sel_ok ? free_pad[in_sel] : 1'b1);
  assign accept   = in_valid && in_ready;
  assign drop     = accept && !in_bcast && !sel_ok;
  assign drop_cnt = drop_cnt_reg;

  generate
    for (genvar gi = 0; gi < NUM_PAD; gi++) begin : g_chan
      if (gi < NUM_OUT) begin : g_real
        logic              vld_reg;
        logic [DATA_W-1:0] dat_reg;
        logic              load;

        assign free[gi]     = !vld_reg || out_ready[gi];
        assign free_pad[gi] = free[gi];
        assign load         = accept && (in_bcast || (in_sel == SEL_W'(gi)));

        // A load wins over a drain so a ready consumer sees one beat per cycle.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            vld_reg <= 1'b0;
            dat_reg <= '0;
          end else if (load) begin
            vld_reg <= 1'b1;
            dat_reg <= in_data;
          end else if (out_ready[gi]) begin
            vld_reg <= 1'b0;
          end
        end

        assign out_valid[gi]                  = vld_reg;
        assign out_data[gi*DATA_W +: DATA_W]  = dat_reg;
      end else begin : g_pad
        assign free_pad[gi] = 1'b1;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_reg <= '0;
    end else if (drop && (drop_cnt_reg != {CNT_W{1'b1}})) begin
      drop_cnt_reg <= drop_cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: directed scenarios plus randomized traffic checked
// against per-channel queues, on an 8-channel and a 5-channel instance.
module tb_stream_demux;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 8-channel instance
  logic        a_valid, a_ready, a_bcast;
  logic [7:0]  a_data;
  logic [2:0]  a_sel;
  logic [7:0]  a_ovalid, a_oready;
  logic [63:0] a_odata;
  logic [7:0]  a_drop;

  // 5-channel instance with a 2-bit drop counter
  logic        b_valid, b_ready, b_bcast;
  logic [7:0]  b_data;
  logic [2:0]  b_sel;
  logic [4:0]  b_ovalid, b_oready;
  logic [39:0] b_odata;
  logic [1:0]  b_drop;

  int checks = 0;
  int errors = 0;

  logic [7:0] mq [8][$];

  stream_demux #(.DATA_W(8), .NUM_OUT(8), .CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_valid), .in_ready(a_ready), .in_data(a_data),
    .in_sel(a_sel), .in_bcast(a_bcast),
    .out_valid(a_ovalid), .out_ready(a_oready), .out_data(a_odata),
    .drop_cnt(a_drop)
  );

  stream_demux #(.DATA_W(8), .NUM_OUT(5), .CNT_W(2)) dut5 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_valid), .in_ready(b_ready), .in_data(b_data),
    .in_sel(b_sel), .in_bcast(b_bcast),
    .out_valid(b_ovalid), .out_ready(b_oready), .out_data(b_odata),
    .drop_cnt(b_drop)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    chk("reset_a_ovalid", 64'(a_ovalid), 64'h0);
    chk("reset_a_odata", a_odata, 64'h0);
    chk("reset_a_drop", 64'(a_drop), 64'h0);
    chk("reset_b_ovalid", 64'(b_ovalid), 64'h0);
    chk("reset_b_drop", 64'(b_drop), 64'h0);
    a_oready = 8'h00;
    a_valid = 1'b1; a_sel = 3'd2; a_data = 8'h22;
    tick();
    a_sel = 3'd5; a_data = 8'h55;
    tick();
    a_valid = 1'b0;
    $display("reset: held beats ovalid=%h", a_ovalid);
    chk("held_ovalid", 64'(a_ovalid), 64'h24);
    #2 rst_n = 1'b0;
    #1;
    $display("reset: async assert ovalid=%h odata=%h", a_ovalid, a_odata);
    chk("async_ovalid", 64'(a_ovalid), 64'h0);
    chk("async_odata", a_odata, 64'h0);
    chk("async_drop", 64'(a_drop), 64'h0);
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_unicast_sweep();
    a_oready = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      a_valid = 1'b1; a_sel = 3'(k); a_bcast = 1'b0; a_data = 8'h10 + 8'(k);
      #1;
      chk("sweep_ready", 64'(a_ready), 64'h1);
      tick();
      $display("sweep: sel=%0d ovalid=%h data=%h", k, a_ovalid, a_odata[k*8 +: 8]);
      chk("sweep_ovalid", 64'(a_ovalid), 64'h1 << k);
      chk("sweep_data", 64'(a_odata[k*8 +: 8]), 64'h10 + 64'(k));
    end
    a_valid = 1'b0;
    tick();
    chk("sweep_drained", 64'(a_ovalid), 64'h0);
  endtask

  task automatic test_backpressure();
    a_oready = 8'hF7;
    a_valid = 1'b1; a_bcast = 1'b0; a_sel = 3'd3; a_data = 8'hA1;
    #1 chk("bp_first_ready", 64'(a_ready), 64'h1);
    tick();
    a_data = 8'hA2;
    #1 chk("bp_second_ready", 64'(a_ready), 64'h0);
    tick();
    chk("bp_ch3_hold", 64'(a_odata[31:24]), 64'hA1);
    a_sel = 3'd4; a_data = 8'hB0;
    #1 chk("bp_ch4_ready", 64'(a_ready), 64'h1);
    tick();
    $display("bp: ovalid=%h ch3=%h ch4=%h", a_ovalid, a_odata[31:24], a_odata[39:32]);
    chk("bp_ovalid", 64'(a_ovalid), 64'h18);
    chk("bp_ch4_data", 64'(a_odata[39:32]), 64'hB0);
    chk("bp_ch3_stable", 64'(a_odata[31:24]), 64'hA1);
    a_oready = 8'hFF; a_sel = 3'd3; a_data = 8'hA2;
    #1 chk("bp_drain_ready", 64'(a_ready), 64'h1);
    tick();
    $display("bp: drain+load ovalid=%h ch3=%h", a_ovalid, a_odata[31:24]);
    chk("bp_reload_ovalid", 64'(a_ovalid), 64'h08);
    chk("bp_reload_data", 64'(a_odata[31:24]), 64'hA2);
    a_valid = 1'b0;
    tick();
  endtask

  task automatic test_broadcast();
    a_oready = 8'hBF;
    a_valid = 1'b1; a_bcast = 1'b0; a_sel = 3'd6; a_data = 8'h66;
    tick();
    a_bcast = 1'b1; a_sel = 3'd1; a_data = 8'h5A;
    #1 chk("bcast_blocked_ready", 64'(a_ready), 64'h0);
    tick();
    $display("bcast: blocked ovalid=%h ch6=%h", a_ovalid, a_odata[55:48]);
    chk("bcast_no_partial", 64'(a_ovalid), 64'h40);
    chk("bcast_ch6_kept", 64'(a_odata[55:48]), 64'h66);
    a_oready = 8'hFF;
    #1 chk("bcast_ready", 64'(a_ready), 64'h1);
    tick();
    $display("bcast: delivered ovalid=%h odata=%h", a_ovalid, a_odata);
    chk("bcast_ovalid", 64'(a_ovalid), 64'hFF);
    chk("bcast_odata", a_odata, {8{8'h5A}});
    a_valid = 1'b0; a_bcast = 1'b0;
    tick();
  endtask

  task automatic test_out_of_range();
    b_oready = 5'h1F;
    b_valid = 1'b1; b_bcast = 1'b0; b_sel = 3'd6; b_data = 8'hEE;
    for (int i = 1; i <= 4; i++) begin
      #1 chk("oor_ready", 64'(b_ready), 64'h1);
      tick();
      $display("oor: beat %0d ovalid=%h drop_cnt=%0d", i, b_ovalid, b_drop);
      chk("oor_ovalid", 64'(b_ovalid), 64'h0);
      chk("oor_drop", 64'(b_drop), (i > 3) ? 64'd3 : 64'(i));
    end
    b_valid = 1'b0;
    tick();
  endtask

  task automatic test_random(input int which, input int cycles);
    int         n;
    int         dmax;
    int         exp_drop;
    logic [7:0] ov, orr, exp_ov;
    logic [63:0] od;
    logic       v, bc, exp_rdy, rdy;
    logic [2:0] sel;
    logic [7:0] dat;
    int         txn;
    n = (which == 1) ? 5 : 8;
    dmax = (which == 1) ? 3 : 255;
    exp_drop = 0;
    txn = 0;
    for (int k = 0; k < 8; k++) mq[k].delete();
    a_valid = 1'b0; b_valid = 1'b0;
    do_reset();
    for (int c = 0; c < cycles; c++) begin
      ov = (which == 1) ? {3'b0, b_ovalid} : a_ovalid;
      od = (which == 1) ? {24'b0, b_odata} : a_odata;
      exp_ov = '0;
      for (int k = 0; k < n; k++) exp_ov[k] = (mq[k].size() > 0);
      chk("rand_ovalid", 64'(ov), 64'(exp_ov));
      for (int k = 0; k < n; k++)
        if (mq[k].size() > 0) chk("rand_data", 64'(od[k*8 +: 8]), 64'(mq[k][0]));
      chk("rand_drop", (which == 1) ? 64'(b_drop) : 64'(a_drop), 64'(exp_drop));

      v   = ($urandom_range(0, 3) != 0);
      bc  = ($urandom_range(0, 7) == 0);
      sel = 3'($urandom_range(0, 7));
      dat = 8'($urandom);
      orr = '0;
      for (int k = 0; k < n; k++) orr[k] = ($urandom_range(0, 3) != 0);
      if (which == 1) begin
        b_valid = v; b_bcast = bc; b_sel = sel; b_data = dat; b_oready = orr[4:0];
      end else begin
        a_valid = v; a_bcast = bc; a_sel = sel; a_data = dat; a_oready = orr;
      end
      #1;
      exp_rdy = 1'b1;
      if (bc) begin
        for (int k = 0; k < n; k++)
          if (mq[k].size() > 0 && !orr[k]) exp_rdy = 1'b0;
      end else if (int'(sel) < n) begin
        exp_rdy = (mq[sel].size() == 0) || orr[sel];
      end
      rdy = (which == 1) ? b_ready : a_ready;
      chk("rand_ready", 64'(rdy), 64'(exp_rdy));

      for (int k = 0; k < n; k++)
        if (mq[k].size() > 0 && orr[k]) void'(mq[k].pop_front());
      if (v && exp_rdy) begin
        txn++;
        if (bc) begin
          for (int k = 0; k < n; k++) mq[k].push_back(dat);
        end else if (int'(sel) < n) begin
          mq[sel].push_back(dat);
        end else if (exp_drop < dmax) begin
          exp_drop++;
        end
      end
      tick();
    end
    $display("random: nout=%0d cycles=%0d accepted=%0d drops=%0d", n, cycles, txn, exp_drop);
    a_valid = 1'b0; b_valid = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    a_valid = 1'b0; a_bcast = 1'b0; a_data = '0; a_sel = '0; a_oready = '0;
    b_valid = 1'b0; b_bcast = 1'b0; b_data = '0; b_sel = '0; b_oready = '0;
    test_reset();
    test_unicast_sweep();
    test_backpressure();
    test_broadcast();
    test_out_of_range();
    test_random(0, 2000);
    test_random(1, 2000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
